// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues level-style word reads, and parks
// a word that completes during a stall so it is delivered exactly once.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        flush,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus1_out,
  output logic        fetch_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_inc;

  assign pc_inc       = pc_q + 16'd1;
  // The request must drop the instant reset asserts, not at the next edge.
  assign imem_req     = reset && (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_out_q;
  assign pc_plus1_out = pc_plus1_q;
  assign fetch_valid  = valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_instr_q <= 16'h0000;
      buf_pc_q    <= 16'h0000;
      instr_q     <= NOP_WORD;
      pc_out_q    <= 16'h0000;
      pc_plus1_q  <= 16'h0000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      pc_plus1_q  <= pc_plus1_d;
      valid_q     <= valid_d;
    end
  end

  // Flush beats stall beats ready; a word that lands during a stall is parked in HOLD.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    pc_plus1_d  = pc_plus1_q;
    valid_d     = valid_q;

    case (state_q)
      FETCH: begin
        if (flush) begin
          pc_d    = branch_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (pc_write) begin
          if (imem_ready) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_inc;
            state_d     = HOLD;
          end
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          pc_out_d   = pc_q;
          pc_plus1_d = pc_inc;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
        end else begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = branch_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!pc_write) begin
          instr_d    = buf_instr_q;
          pc_out_d   = buf_pc_q;
          pc_plus1_d = buf_pc_q + 16'd1;
          valid_d    = 1'b1;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a queue-based delivery model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hF000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcWrite = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branchTarget = 16'h0000;
  logic        imemReady = 1'b0;

  logic        imemReq, imemReqW;
  logic [15:0] imemAddr, imemAddrW, imemRdata, imemRdataW;
  logic [15:0] instrOut, pcOut, pcPlus1Out;
  logic [15:0] instrOutW, pcOutW, pcPlus1OutW;
  logic        fetchValid, fetchValidW;

  int errors = 0;
  int checks = 0;

  logic [15:0] mPc, mInstr, mPcOut, mPcP1, expNext;
  logic        mValid, delivered;
  word_t       parked[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  assign imemRdata  = imemReady ? memWord(imemAddr)  : 16'hDEAD;
  assign imemRdataW = imemReady ? memWord(imemAddrW) : 16'hDEAD;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_write(pcWrite), .flush(flush),
    .branch_target(branchTarget), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_rdata(imemRdata), .imem_ready(imemReady), .instr_out(instrOut),
    .pc_out(pcOut), .pc_plus1_out(pcPlus1Out), .fetch_valid(fetchValid)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dutWrap (
    .clk(clk), .reset(reset), .pc_write(pcWrite), .flush(flush),
    .branch_target(branchTarget), .imem_req(imemReqW), .imem_addr(imemAddrW),
    .imem_rdata(imemRdataW), .imem_ready(imemReady), .instr_out(instrOutW),
    .pc_out(pcOutW), .pc_plus1_out(pcPlus1OutW), .fetch_valid(fetchValidW)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 16'h0000; mInstr = NOP; mPcOut = 16'h0000; mPcP1 = 16'h0000;
    mValid = 1'b0; expNext = 16'h0000; parked.delete();
  endtask

  task automatic deliver(input logic [15:0] instr, input logic [15:0] pc);
    mInstr = instr; mPcOut = pc; mPcP1 = pc + 16'd1; mValid = 1'b1; delivered = 1'b1;
  endtask

  // Behavioural view: a fetched word is either delivered now or parked until the stall clears.
  task automatic modelEdge();
    word_t w;
    delivered = 1'b0;
    if (flush) begin
      parked.delete();
      mPc = branchTarget; mInstr = NOP; mValid = 1'b0; expNext = branchTarget;
    end else if (parked.size() != 0) begin
      if (!pcWrite) begin
        w = parked.pop_front();
        deliver(w.instr, w.pc);
      end
    end else if (imemReady) begin
      if (pcWrite) begin
        w.instr = memWord(mPc); w.pc = mPc;
        parked.push_back(w);
      end else begin
        deliver(memWord(mPc), mPc);
      end
      mPc = mPc + 16'd1;
    end else if (!pcWrite) begin
      mInstr = NOP; mValid = 1'b0;
    end
  endtask

  task automatic compareRegs();
    checkOutput("instr_out", {16'h0, instrOut}, {16'h0, mInstr});
    checkOutput("pc_out", {16'h0, pcOut}, {16'h0, mPcOut});
    checkOutput("pc_plus1_out", {16'h0, pcPlus1Out}, {16'h0, mPcP1});
    checkOutput("fetch_valid", {31'h0, fetchValid}, {31'h0, mValid});
    if (delivered) begin
      checkOutput("delivery_order", {16'h0, pcOut}, {16'h0, expNext});
      expNext = expNext + 16'd1;
    end
  endtask

  // Called just after a negedge: drive, check the combinational request, clock once, check.
  task automatic applyStimulus(input logic f, input logic [15:0] bt, input logic pw, input logic rdy);
    flush = f; branchTarget = bt; pcWrite = pw; imemReady = rdy;
    #1;
    checkOutput("imem_req", {31'h0, imemReq}, {31'h0, (parked.size() == 0)});
    checkOutput("imem_addr", {16'h0, imemAddr}, {16'h0, mPc});
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareRegs();
  endtask

  logic [15:0] wrapPc[3];
  logic [15:0] wrapP1[3];

  task automatic streamWithWrapCheck();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("wrap_pc_out", {16'h0, pcOutW}, {16'h0, wrapPc[i]});
      checkOutput("wrap_pc_plus1", {16'h0, pcPlus1OutW}, {16'h0, wrapP1[i]});
      checkOutput("wrap_valid", {31'h0, fetchValidW}, 32'h1);
    end
  endtask

  initial begin
    wrapPc[0] = 16'hFFFE; wrapPc[1] = 16'hFFFF; wrapPc[2] = 16'h0000;
    wrapP1[0] = 16'hFFFF; wrapP1[1] = 16'h0000; wrapP1[2] = 16'h0001;
    modelReset();
    delivered = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_instr", {16'h0, instrOut}, {16'h0, NOP});
    checkOutput("reset_valid", {31'h0, fetchValid}, 32'h0);
    checkOutput("reset_req", {31'h0, imemReq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait streaming; the second instance checks PC wrap-around
    streamWithWrapCheck();
    checkOutput("stream_instr2", {16'h0, instrOut}, 32'h0000A5A7);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Stall on the same edge that address 5 completes
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("stall_hold_pc", {16'h0, pcOut}, 32'h4);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("hold_req_low", {31'h0, imemReq}, 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("unpark_instr", {16'h0, instrOut}, {16'h0, memWord(16'h5)});
    checkOutput("unpark_pc", {16'h0, pcOut}, 32'h5);
    checkOutput("next_addr", {16'h0, imemAddr}, 32'h6);

    // Two wait states per fetch
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, (i % 3) == 2);
      if ((i % 3) == 0) checkOutput("wait_nop", {16'h0, instrOut}, {16'h0, NOP});
    end

    // Flush dominates stall and ready
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b1);
    checkOutput("flush_instr", {16'h0, instrOut}, {16'h0, NOP});
    checkOutput("flush_addr", {16'h0, imemAddr}, 32'h40);

    // Flush out of HOLD drops the parked word
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0080, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("post_flush_pc", {16'h0, pcOut}, 32'h80);

    // Flush to the current PC still refetches
    applyStimulus(1'b1, mPc, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, 16'($urandom()),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
    end

    // Async reset asserted between edges while parked
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_instr", {16'h0, instrOut}, {16'h0, NOP});
    checkOutput("async_pc", {16'h0, pcOut}, 32'h0);
    checkOutput("async_p1", {16'h0, pcPlus1Out}, 32'h0);
    checkOutput("async_valid", {31'h0, fetchValid}, 32'h0);
    checkOutput("async_req", {31'h0, imemReq}, 32'h0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    streamWithWrapCheck();
    checkOutput("restart_pc", {16'h0, pcOut}, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
